// File: rtl/masked_match_bank.sv
// Multi-channel masked equality comparator: per-channel loadable reference and mask,
// registered active-low match, lowest-index hit encoder, saturating hit counters and sticky flags.
module masked_match_bank #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          sysclk,
    input  logic                          sys_rst_n,
    input  logic                          load,
    input  logic [SEL_W-1:0]              load_sel,
    input  logic [WIDTH-1:0]              load_ref,
    input  logic [WIDTH-1:0]              load_mask,
    input  logic [CHANNELS-1:0]           ch_en,
    input  logic                          data_valid,
    input  logic [WIDTH-1:0]              data,
    input  logic                          clr,
    output logic [CHANNELS-1:0]           match_n,
    output logic                          any_match_n,
    output logic [SEL_W-1:0]              hit_idx,
    output logic [CHANNELS*CNT_WIDTH-1:0] hit_cnt,
    output logic [CHANNELS-1:0]           sticky
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]              ref_q  [CHANNELS];
    logic [WIDTH-1:0]              mask_q [CHANNELS];
    logic [CHANNELS-1:0]           hit;
    logic [SEL_W-1:0]              hit_idx_nxt;
    logic [CHANNELS*CNT_WIDTH-1:0] cnt_q;
    logic [CHANNELS-1:0]           sticky_q;
    logic [CHANNELS-1:0]           match_n_q;
    logic                          any_match_n_q;
    logic [SEL_W-1:0]              hit_idx_q;

    // data_valid qualifies data for one cycle only; there is no back-pressure.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = data_valid & ch_en[i] & (((data ^ ref_q[i]) & mask_q[i]) == '0);
        end
    end

    // Scan downward so the lowest-numbered hitting channel wins.
    always_comb begin
        hit_idx_nxt = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx_nxt = SEL_W'(i);
        end
    end

    // Loads compare against every legal index, so an out-of-range load_sel touches nothing.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ref_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_sel == SEL_W'(i)) begin
                    ref_q[i]  <= load_ref;
                    mask_q[i] <= load_mask;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            match_n_q     <= '1;
            any_match_n_q <= 1'b1;
            hit_idx_q     <= '0;
        end else begin
            match_n_q     <= ~hit;
            any_match_n_q <= ~(|hit);
            hit_idx_q     <= hit_idx_nxt;
        end
    end

    // clr overrides any hit in the same cycle for counters and sticky flags.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q    <= '0;
            sticky_q <= '0;
        end else if (clr) begin
            cnt_q    <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) begin
                    sticky_q[i] <= 1'b1;
                    if (cnt_q[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX) begin
                        cnt_q[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
                    end
                end
            end
        end
    end

    assign match_n     = match_n_q;
    assign any_match_n = any_match_n_q;
    assign hit_idx     = hit_idx_q;
    assign hit_cnt     = cnt_q;
    assign sticky      = sticky_q;

endmodule

// File: tb/tb_masked_match_bank.sv
// Directed bench for masked_match_bank with hand-computed expectations.
module tb_masked_match_bank;

    localparam int WIDTH     = 16;
    localparam int CHANNELS  = 4;
    localparam int CNT_WIDTH = 8;
    localparam int SEL_W     = 2;

    logic                          sysclk;
    logic                          sys_rst_n;
    logic                          load;
    logic [SEL_W-1:0]              load_sel;
    logic [WIDTH-1:0]              load_ref;
    logic [WIDTH-1:0]              load_mask;
    logic [CHANNELS-1:0]           ch_en;
    logic                          data_valid;
    logic [WIDTH-1:0]              data;
    logic                          clr;
    logic [CHANNELS-1:0]           match_n;
    logic                          any_match_n;
    logic [SEL_W-1:0]              hit_idx;
    logic [CHANNELS*CNT_WIDTH-1:0] hit_cnt;
    logic [CHANNELS-1:0]           sticky;

    int total = 0;
    int bad   = 0;

    masked_match_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n),
        .load(load), .load_sel(load_sel), .load_ref(load_ref), .load_mask(load_mask),
        .ch_en(ch_en), .data_valid(data_valid), .data(data), .clr(clr),
        .match_n(match_n), .any_match_n(any_match_n), .hit_idx(hit_idx),
        .hit_cnt(hit_cnt), .sticky(sticky)
    );

    // clock / reset
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_load(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] r,
                           input logic [WIDTH-1:0] m);
        load      = 1'b1;
        load_sel  = sel;
        load_ref  = r;
        load_mask = m;
    endtask

    function automatic logic [CNT_WIDTH-1:0] cnt_of(input int i);
        return hit_cnt[i*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_match_n"}, 64'(match_n), 64'hF);
        check({tag, "_any"},     64'(any_match_n), 64'h1);
        check({tag, "_idx"},     64'(hit_idx), 64'h0);
        check({tag, "_cnt"},     64'(hit_cnt), 64'h0);
        check({tag, "_sticky"},  64'(sticky), 64'h0);
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        load       = 1'b0;
        load_sel   = '0;
        load_ref   = '0;
        load_mask  = '0;
        ch_en      = '0;
        data_valid = 1'b0;
        data       = '0;
        clr        = 1'b0;
        #23;
        check_reset_state("rst");
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        tick();

        // 1: exact match on channel 0
        do_load(2'd0, 16'h1234, 16'hFFFF);
        tick();
        load = 1'b0; ch_en = 4'b0001; data_valid = 1'b1; data = 16'h1234;
        tick();
        check("t1_match_n", 64'(match_n), 64'hE);
        check("t1_any", 64'(any_match_n), 64'h0);
        check("t1_idx", 64'(hit_idx), 64'h0);
        check("t1_cnt0", 64'(cnt_of(0)), 64'd1);
        check("t1_sticky", 64'(sticky), 64'h1);

        // 2: masked compare on channel 1, priority encoding
        data_valid = 1'b0;
        do_load(2'd1, 16'h12F0, 16'hFF00);
        tick();
        check("t2_idle_match_n", 64'(match_n), 64'hF);
        load = 1'b0; ch_en = 4'b0011; data_valid = 1'b1; data = 16'h1234;
        tick();
        check("t2a_match_n", 64'(match_n), 64'hC);
        check("t2a_idx", 64'(hit_idx), 64'h0);
        data = 16'h12AA;
        tick();
        check("t2b_match_n", 64'(match_n), 64'hD);
        check("t2b_idx", 64'(hit_idx), 64'h1);
        check("t2b_cnt", 64'(hit_cnt), 64'h0000_0202);
        check("t2b_sticky", 64'(sticky), 64'h3);

        // all-zero mask on channel 2 matches any word; ch1 also hits -> idx 1
        ch_en = 4'b0100; data = 16'hBEEF;
        tick();
        check("mask0_match_n", 64'(match_n), 64'hB);
        check("mask0_idx", 64'(hit_idx), 64'h2);
        ch_en = 4'b0110; data = 16'h12AA;
        tick();
        check("multi_match_n", 64'(match_n), 64'h9);
        check("multi_idx", 64'(hit_idx), 64'h1);
        ch_en = 4'b0000;
        tick();
        check("en_off_match_n", 64'(match_n), 64'hF);
        check("en_off_any", 64'(any_match_n), 64'h1);

        // 3: saturation of channel 0 counter
        ch_en = 4'b0001; data = 16'h1234;
        for (int i = 0; i < 300; i++) tick();
        check("t3_cnt0_sat", 64'(cnt_of(0)), 64'd255);
        check("t3_cnt1_hold", 64'(cnt_of(1)), 64'd3);
        check("t3_cnt2_hold", 64'(cnt_of(2)), 64'd2);
        tick();
        check("t3_cnt0_nowrap", 64'(cnt_of(0)), 64'd255);

        // 5: clr wins over a simultaneous hit
        clr = 1'b1;
        tick();
        check("t5_clr_match_n", 64'(match_n), 64'hE);
        check("t5_clr_any", 64'(any_match_n), 64'h0);
        check("t5_clr_cnt", 64'(hit_cnt), 64'h0);
        check("t5_clr_sticky", 64'(sticky), 64'h0);
        clr = 1'b0; data_valid = 1'b0;
        tick();
        check("t5_novalid_match_n", 64'(match_n), 64'hF);
        check("t5_novalid_cnt", 64'(hit_cnt), 64'h0);

        // 4: compare in the load cycle uses the old reference
        do_load(2'd0, 16'h5555, 16'hFFFF);
        data_valid = 1'b1; data = 16'h1234;
        tick();
        check("t4_old_ref_match_n", 64'(match_n), 64'hE);
        check("t4_old_ref_cnt0", 64'(cnt_of(0)), 64'd1);
        load = 1'b0;
        tick();
        check("t4_new_ref_miss", 64'(match_n), 64'hF);
        data = 16'h5555;
        tick();
        check("t4_new_ref_hit", 64'(match_n), 64'hE);
        check("t4_cnt0", 64'(cnt_of(0)), 64'd2);

        // 6: asynchronous reset mid-stream
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_state("t6_async");
        data_valid = 1'b0;
        @(negedge sysclk);
        sys_rst_n = 1'b1;
        do_load(2'd0, 16'h0000, 16'hFFFF);
        tick();
        load = 1'b0; data_valid = 1'b1; data = 16'h1234;
        tick();
        check("t6_reload_miss", 64'(match_n), 64'hF);
        check("t6_reload_sticky", 64'(sticky), 64'h0);
        data = 16'h0000;
        tick();
        check("t6_reload_hit", 64'(match_n), 64'hE);
        check("t6_reload_cnt0", 64'(cnt_of(0)), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
